// File: rtl/rf_wbck_arbiter_pkg.sv
// Shared widths for the register-file write-back path and a pointer-width helper.
package rf_wbck_arbiter_pkg;

  localparam int unsigned RF_XLEN     = 32;
  localparam int unsigned RFIDX_WIDTH = 5;
  localparam int unsigned RFREG_NUM   = 32;

  // A single requester still needs a 1-bit pointer so ports stay legal.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wbck_arbiter_if.sv
// Write-back request, dispatch hazard and register-file write signals of the arbiter.
interface rf_wbck_arbiter_if
  import rf_wbck_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = RF_XLEN,
  parameter int unsigned IDXW = RFIDX_WIDTH,
  parameter int unsigned NREG = RFREG_NUM
);

  logic [NREQ-1:0]      wb_valid;
  logic [NREQ-1:0]      wb_ready;
  logic [NREQ*IDXW-1:0] wb_idx;
  logic [NREQ*XLEN-1:0] wb_dat;
  logic                 disp_valid;
  logic                 disp_ready;
  logic                 disp_rd_wen;
  logic [IDXW-1:0]      disp_rd;
  logic [IDXW-1:0]      disp_rs1;
  logic [IDXW-1:0]      disp_rs2;
  logic                 wbck_dest_wen;
  logic [IDXW-1:0]      wbck_dest_idx;
  logic [XLEN-1:0]      wbck_dest_dat;
  logic [NREG-1:0]      busy_vec;

  modport master (
    output wb_valid, wb_idx, wb_dat, disp_valid, disp_rd_wen, disp_rd, disp_rs1, disp_rs2,
    input  wb_ready, disp_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, busy_vec
  );

  modport slave (
    input  wb_valid, wb_idx, wb_dat, disp_valid, disp_rd_wen, disp_rd, disp_rs1, disp_rs2,
    output wb_ready, disp_ready, wbck_dest_wen, wbck_dest_idx, wbck_dest_dat, busy_vec
  );

endinterface

// File: rtl/rf_wbck_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner.
module rr_arbiter
  import rf_wbck_arbiter_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    logic [PW-1:0] w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = PW'((32'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/rf_wbck_arbiter.sv
// Sole owner of the register-file write port: round-robin write-back arbitration,
// registered write, and a busy scoreboard that stalls dispatch on RAW/WAW hazards.
module rf_wbck_arbiter
  import rf_wbck_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = RF_XLEN,
  parameter int unsigned IDXW = RFIDX_WIDTH,
  parameter int unsigned NREG = RFREG_NUM
) (
  input logic               clk,
  input logic               rst,
  rf_wbck_arbiter_if.slave  bus
);

  localparam int unsigned PW = ptr_width(NREQ);

  logic [PW-1:0]   r_ptr;
  logic            r_wen;
  logic [IDXW-1:0] r_idx;
  logic [XLEN-1:0] r_dat;
  logic [NREG-1:0] r_busy;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_gidx;
  logic            w_gvalid;
  logic [IDXW-1:0] w_sel_idx;
  logic [XLEN-1:0] w_sel_dat;
  logic            w_busy_rs1;
  logic            w_busy_rs2;
  logic            w_busy_rd;
  logic            w_disp_fire;
  logic [NREG-1:0] w_busy_d;

  function automatic logic busy_of(input logic [NREG-1:0] vec, input logic [IDXW-1:0] idx);
    busy_of = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (idx == IDXW'(r)) busy_of = vec[r];
    end
  endfunction

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .i_req   (bus.wb_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  always_comb begin
    w_sel_idx = '0;
    w_sel_dat = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_idx = w_sel_idx | bus.wb_idx[i*IDXW +: IDXW];
        w_sel_dat = w_sel_dat | bus.wb_dat[i*XLEN +: XLEN];
      end
    end
  end

  assign w_busy_rs1  = busy_of(r_busy, bus.disp_rs1);
  assign w_busy_rs2  = busy_of(r_busy, bus.disp_rs2);
  assign w_busy_rd   = busy_of(r_busy, bus.disp_rd);
  assign w_disp_fire = bus.disp_valid & bus.disp_ready & bus.disp_rd_wen &
                       (bus.disp_rd != '0);

  // Clear on the RF write edge, then set: a same-cycle set of the same index wins.
  always_comb begin
    w_busy_d = r_busy;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (r_wen && r_idx == IDXW'(r)) w_busy_d[r] = 1'b0;
      if (w_disp_fire && bus.disp_rd == IDXW'(r)) w_busy_d[r] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= PW'(NREQ - 1);
      r_wen  <= 1'b0;
      r_idx  <= '0;
      r_dat  <= '0;
      r_busy <= '0;
    end else begin
      if (w_gvalid) begin
        r_ptr <= w_gidx;
        r_wen <= (w_sel_idx != '0);
        r_idx <= w_sel_idx;
        r_dat <= w_sel_dat;
      end else begin
        r_wen <= 1'b0;
      end
      r_busy <= w_busy_d;
    end
  end

  assign bus.wb_ready      = w_grant;
  assign bus.disp_ready    = !(w_busy_rs1 | w_busy_rs2 | (bus.disp_rd_wen & w_busy_rd));
  assign bus.wbck_dest_wen = r_wen;
  assign bus.wbck_dest_idx = r_idx;
  assign bus.wbck_dest_dat = r_dat;
  assign bus.busy_vec      = r_busy;

endmodule
